// File: rtl/core_sequencer.sv
// core_sequencer: control sequencer for the attention core.
// Each run loads n_q query vectors and col key rows from the external stream.
// It then pre-loads the kernel, executes n_q queries and drains the output FIFO
// into pmem. An optional normalisation pass (NACC then NDIV) can follow.
//
// Optional feature macro: SEQ_NORM_EN (adds the NACC/NDIV normalisation states).
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   one-cycle run request, honoured only in IDLE
//   n_q        in   query count (1..2^addr_w), captured on an accepted start
//   mem_valid  in   external mem_in word present this cycle
//   fifo_valid in   output FIFO holds a complete row
//   mem_ready  out  mem_in is consumed this cycle when mem_valid is high
//   inst       out  registered core instruction word
//   busy       out  high in every state except IDLE
//   done       out  registered one-cycle pulse marking the end of a run
//   err        out  registered one-cycle pulse for a rejected start
module core_sequencer #(
    parameter int col    = 8,
    parameter int addr_w = 4,
    parameter int inst_w = 12 + 2 * addr_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w:0]   n_q,
    input  logic              mem_valid,
    input  logic              fifo_valid,
    output logic              mem_ready,
    output logic [inst_w-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int cw     = addr_w + 1;
    localparam int qk_lsb = addr_w + 8;
    localparam int pm_lsb = 8;

    localparam int b_get_sum  = inst_w - 1;
    localparam int b_div      = inst_w - 2;
    localparam int b_acc      = inst_w - 3;
    localparam int b_ofifo_rd = inst_w - 4;
    localparam int b_execute  = 7;
    localparam int b_kload    = 6;
    localparam int b_qmem_rd  = 5;
    localparam int b_qmem_wr  = 4;
    localparam int b_kmem_rd  = 3;
    localparam int b_kmem_wr  = 2;
    localparam int b_pmem_rd  = 1;
    localparam int b_pmem_wr  = 0;

    localparam logic [cw-1:0] col_c  = cw'(col);
    localparam logic [cw-1:0] one_c  = cw'(1);
    localparam logic [cw-1:0] max_nq = {1'b1, {addr_w{1'b0}}};

`ifdef SEQ_NORM_EN
    typedef enum logic [3:0] {
        IDLE, LDQ, LDK, KLOAD, EXEC, DRAIN, NACC, NDIV, DONE
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, LDQ, LDK, KLOAD, EXEC, DRAIN, DONE
    } state_t;
`endif

    state_t            state, next_state;
    logic [cw-1:0]     cnt, next_cnt;
    logic [cw-1:0]     nq_reg, next_nq;
    logic [inst_w-1:0] next_inst;
    logic              next_done, next_err;

`ifdef SEQ_NORM_EN
    // Normalisation walks two steps per row, so the last step index is 2*n_q-1.
    logic [cw:0] last_step;
    assign last_step = {nq_reg, 1'b0} - {1'b0, one_c};
`endif

    assign busy      = (state != IDLE);
    assign mem_ready = (state == LDQ) || (state == LDK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            nq_reg <= '0;
            inst   <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            nq_reg <= next_nq;
            inst   <= next_inst;
            done   <= next_done;
            err    <= next_err;
        end
    end

    // Each state computes the instruction word to be registered on the coming
    // edge. Every state change clears cnt so each phase addresses from 0.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_nq    = nq_reg;
        next_inst  = '0;
        next_done  = 1'b0;
        next_err   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_q == '0 || n_q > max_nq) begin
                        next_err = 1'b1;
                    end else begin
                        next_nq    = n_q;
                        next_cnt   = '0;
                        next_state = LDQ;
                    end
                end
            end
            LDQ: begin
                if (mem_valid) begin
                    next_inst[b_qmem_wr]           = 1'b1;
                    next_inst[qk_lsb +: addr_w]    = cnt[addr_w-1:0];
                    if (cnt == nq_reg - one_c) begin
                        next_cnt   = '0;
                        next_state = LDK;
                    end else begin
                        next_cnt = cnt + one_c;
                    end
                end
            end
            LDK: begin
                if (mem_valid) begin
                    next_inst[b_kmem_wr]           = 1'b1;
                    next_inst[qk_lsb +: addr_w]    = cnt[addr_w-1:0];
                    if (cnt == col_c - one_c) begin
                        next_cnt   = '0;
                        next_state = KLOAD;
                    end else begin
                        next_cnt = cnt + one_c;
                    end
                end
            end
            // The extra cycle past col covers the one-cycle kmem read latency.
            KLOAD: begin
                next_inst[b_kload] = 1'b1;
                if (cnt < col_c) begin
                    next_inst[b_kmem_rd]        = 1'b1;
                    next_inst[qk_lsb +: addr_w] = cnt[addr_w-1:0];
                end
                if (cnt == col_c) begin
                    next_cnt   = '0;
                    next_state = EXEC;
                end else begin
                    next_cnt = cnt + one_c;
                end
            end
            EXEC: begin
                next_inst[b_execute] = 1'b1;
                if (cnt < nq_reg) begin
                    next_inst[b_qmem_rd]        = 1'b1;
                    next_inst[qk_lsb +: addr_w] = cnt[addr_w-1:0];
                end
                if (cnt == nq_reg) begin
                    next_cnt   = '0;
                    next_state = DRAIN;
                end else begin
                    next_cnt = cnt + one_c;
                end
            end
            DRAIN: begin
                if (fifo_valid && cnt < nq_reg) begin
                    next_inst[b_ofifo_rd]       = 1'b1;
                    next_inst[b_pmem_wr]        = 1'b1;
                    next_inst[pm_lsb +: addr_w] = cnt[addr_w-1:0];
                    if (cnt == nq_reg - one_c) begin
                        next_cnt   = '0;
`ifdef SEQ_NORM_EN
                        next_state = NACC;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_cnt = cnt + one_c;
                    end
                end
            end
`ifdef SEQ_NORM_EN
            // cnt[0] selects the read or write half of a row; cnt >> 1 is the row.
            NACC, NDIV: begin
                next_inst[pm_lsb +: addr_w] = cnt[addr_w:1];
                if (!cnt[0]) begin
                    next_inst[b_pmem_rd]  = 1'b1;
                    next_inst[b_get_sum]  = (state == NDIV);
                end else begin
                    next_inst[b_pmem_wr]  = 1'b1;
                    next_inst[b_acc]      = (state == NACC);
                    next_inst[b_div]      = (state == NDIV);
                end
                if ({1'b0, cnt} == last_step) begin
                    next_cnt   = '0;
                    next_state = (state == NACC) ? NDIV : DONE;
                end else begin
                    next_cnt = cnt + one_c;
                end
            end
`endif
            DONE: begin
                next_done  = 1'b1;
                next_cnt   = '0;
                next_state = IDLE;
            end
            default: begin
                next_cnt   = '0;
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed self-checking bench for core_sequencer.
// Inputs are changed and outputs are sampled on the falling clock edge.
module tb_core_sequencer;

    localparam int COL = 8;
    localparam int AW  = 4;
    localparam int IW  = 12 + 2 * AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   n_q;
    logic          mem_valid;
    logic          fifo_valid;
    logic          mem_ready;
    logic [IW-1:0] inst;
    logic          busy;
    logic          done;
    logic          err;

    core_sequencer #(.col(COL), .addr_w(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_q        (n_q),
        .mem_valid  (mem_valid),
        .fifo_valid (fifo_valid),
        .mem_ready  (mem_ready),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-run observation record.
    int q_wr_n, k_wr_n, kload_n, krd_n, exec_n, qrd_n;
    int done_n, err_n, busy_low_n, ready_n, stray_n, stall_strobe_n;
    int max_qk, cyc_i, last_drain_cyc, done_cyc;
    int q_addr[$];
    int k_addr[$];
    int d_addr[$];
    int norm_log[$];
    bit last_mv, last_fv, seen_done;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        q_wr_n = 0; k_wr_n = 0; kload_n = 0; krd_n = 0; exec_n = 0; qrd_n = 0;
        done_n = 0; err_n = 0; busy_low_n = 0; ready_n = 0; stray_n = 0;
        stall_strobe_n = 0; max_qk = -1; cyc_i = 0; last_drain_cyc = -100;
        done_cyc = -1; seen_done = 0;
        q_addr.delete(); k_addr.delete(); d_addr.delete(); norm_log.delete();
    endtask

    // Decode the instruction word produced by the edge just passed.
    task automatic observe();
        logic [AW-1:0] qk;
        logic [AW-1:0] pm;
        qk = inst[AW+8 +: AW];
        pm = inst[8 +: AW];
        cyc_i++;
        if (inst[4]) begin
            q_wr_n++; q_addr.push_back(int'(qk));
            if (!last_mv) stray_n++;
        end
        if (inst[2]) begin
            k_wr_n++; k_addr.push_back(int'(qk));
            if (!last_mv) stray_n++;
        end
        if ((inst[4] | inst[2] | inst[3] | inst[5]) && int'(qk) > max_qk) max_qk = int'(qk);
        if (inst[6]) kload_n++;
        if (inst[3]) krd_n++;
        if (inst[7]) exec_n++;
        if (inst[5]) qrd_n++;
        if (inst[IW-4]) begin
            d_addr.push_back(int'(pm));
            last_drain_cyc = cyc_i;
            if (!last_fv) stall_strobe_n++;
            if (!inst[0]) stray_n++;
        end else if (inst[0] | inst[1]) begin
            norm_log.push_back(int'({inst[IW-1], inst[IW-2], inst[IW-3], inst[1], inst[0], pm}));
        end
        if (done) begin
            done_n++;
            if (!seen_done) done_cyc = cyc_i;
            seen_done = 1;
        end
        if (err) err_n++;
        if (!seen_done && !busy) busy_low_n++;
        if (mem_ready) ready_n++;
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
    endtask

    // Runs one complete sequence. toggle alternates mem_valid, stall freezes the
    // FIFO for five cycles after the first drained row, poke_start issues a
    // bogus start while the sequencer is busy.
    task automatic applyStimulus(input int nq, input bit toggle, input bit stall,
                                 input bit poke_start);
        int  stall_left;
        bit  stall_used;
        logic [AW:0] nq_v;
        stall_left = 0;
        stall_used = 0;
        clearMon();
        nq_v       = nq[AW:0];
        n_q        = nq_v;
        start      = 1'b1;
        mem_valid  = 1'b0;
        fifo_valid = 1'b1;
        last_mv    = 1'b0;
        last_fv    = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 400 && !seen_done; i++) begin
            mem_valid = (toggle && (i % 2 != 0)) ? 1'b0 : 1'b1;
            if (stall_left > 0) begin
                fifo_valid = 1'b0;
                stall_left--;
            end else begin
                fifo_valid = 1'b1;
            end
            if (poke_start && i == 2) begin
                start = 1'b1;
                n_q   = '0;
            end else begin
                start = 1'b0;
            end
            last_mv = mem_valid;
            last_fv = fifo_valid;
            cyc();
            if (stall && !stall_used && d_addr.size() == 1) begin
                stall_left = 5;
                stall_used = 1;
            end
        end
        start     = 1'b0;
        mem_valid = 1'b0;
        checkOutput("timeout", seen_done ? 1 : 0, 1);
        cyc();
    endtask

    task automatic checkList(input string tag, input int n, input int which);
        int got;
        for (int k = 0; k < n; k++) begin
            got = -1;
            if (which == 0 && k < q_addr.size()) got = q_addr[k];
            if (which == 1 && k < k_addr.size()) got = k_addr[k];
            if (which == 2 && k < d_addr.size()) got = d_addr[k];
            checkOutput($sformatf("%s%0d", tag, k), got, k);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        n_q        = '0;
        mem_valid  = 1'b0;
        fifo_valid = 1'b0;
        last_mv    = 1'b0;
        last_fv    = 1'b0;
        clearMon();
        cyc();
        cyc();
        checkOutput("rst_inst", int'(inst), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_ready", int'(mem_ready), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);
        reset = 1'b1;
        cyc();

        // Basic run, n_q=3, mem_valid held high, stray start while busy.
        applyStimulus(3, 1'b0, 1'b0, 1'b1);
        checkOutput("q_wr_n", q_wr_n, 3);
        checkList("q_addr", 3, 0);
        checkOutput("k_wr_n", k_wr_n, 8);
        checkList("k_addr", 8, 1);
        checkOutput("kload_n", kload_n, 9);
        checkOutput("krd_n", krd_n, 8);
        checkOutput("exec_n", exec_n, 4);
        checkOutput("qrd_n", qrd_n, 3);
        checkOutput("drain_n", d_addr.size(), 3);
        checkList("d_addr", 3, 2);
        checkOutput("done_n", done_n, 1);
        checkOutput("busy_low", busy_low_n, 0);
        checkOutput("ready_n", ready_n, 11);
        checkOutput("stray", stray_n, 0);
        checkOutput("busy_err", err_n, 0);
        checkOutput("idle_busy", int'(busy), 0);

        // mem_valid toggling during LDQ.
        applyStimulus(3, 1'b1, 1'b0, 1'b0);
        checkOutput("tg_q_wr_n", q_wr_n, 3);
        checkList("tg_q_addr", 3, 0);
        checkOutput("tg_stray", stray_n, 0);
        checkOutput("tg_done_n", done_n, 1);

        // Rejected starts.
        start = 1'b1; n_q = '0;
        cyc();
        checkOutput("err_nq0", int'(err), 1);
        checkOutput("busy_nq0", int'(busy), 0);
        start = 1'b0;
        cyc();
        checkOutput("err_clear", int'(err), 0);
        start = 1'b1; n_q = 5'd17;
        cyc();
        checkOutput("err_nq17", int'(err), 1);
        checkOutput("busy_nq17", int'(busy), 0);
        start = 1'b0;
        cyc();
        checkOutput("err_clear2", int'(err), 0);

        // Largest query count.
        applyStimulus(16, 1'b0, 1'b0, 1'b0);
        checkOutput("n16_q_wr_n", q_wr_n, 16);
        checkOutput("n16_max_qk", max_qk, 15);
        checkOutput("n16_last_q", q_addr.size() == 16 ? q_addr[15] : -1, 15);
        checkOutput("n16_exec_n", exec_n, 17);
        checkOutput("n16_drain_n", d_addr.size(), 16);
        checkOutput("n16_err", err_n, 0);

        // FIFO stall after the first drained row.
        applyStimulus(4, 1'b0, 1'b1, 1'b0);
        checkOutput("st_drain_n", d_addr.size(), 4);
        checkList("st_d_addr", 4, 2);
        checkOutput("st_strobe", stall_strobe_n, 0);

        // Normalisation pass (or its absence).
        applyStimulus(2, 1'b0, 1'b0, 1'b0);
        checkOutput("n2_drain_n", d_addr.size(), 2);
`ifdef SEQ_NORM_EN
        begin
            int exp_log[8];
            exp_log = '{32, 80, 33, 81, 288, 144, 289, 145};
            checkOutput("norm_n", norm_log.size(), 8);
            for (int k = 0; k < 8; k++)
                checkOutput($sformatf("norm%0d", k), k < norm_log.size() ? norm_log[k] : -1, exp_log[k]);
        end
`else
        checkOutput("norm_n", norm_log.size(), 0);
        checkOutput("done_gap", done_cyc - last_drain_cyc, 1);
`endif

        // Reset during EXEC aborts; next run is complete.
        clearMon();
        start = 1'b1; n_q = 5'd3; mem_valid = 1'b1; last_mv = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 100 && exec_n == 0; i++) cyc();
        checkOutput("reach_exec", exec_n > 0 ? 1 : 0, 1);
        reset = 1'b0;
        cyc();
        checkOutput("abort_inst", int'(inst), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_ready", int'(mem_ready), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checkOutput($sformatf("post_inst%0d", i), int'(inst), 0);
        end
        mem_valid = 1'b0;
        applyStimulus(3, 1'b0, 1'b0, 1'b0);
        checkOutput("rr_q_wr_n", q_wr_n, 3);
        checkList("rr_q_addr", 3, 0);
        checkOutput("rr_exec_n", exec_n, 4);
        checkOutput("rr_done_n", done_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
